// File: rtl/tutor_quiz_controller.sv
// Quiz sequencer/scorer: draws LFSR questions, latches the checker verdict, grades student answers.
// Latency: answer in WAIT_ANS -> correct/wrong pulse 1 cycle later; question re-presented 2 cycles after feedback.
// Backpressure: none; answers/starts outside their accepting state are dropped, the quiz waits on the student.
module tutor_quiz_controller #(
  parameter int unsigned NUM_QUESTIONS  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ans_valid,
  input  logic       ans_yes,
  input  logic       ismultiple,
  output logic [2:0] q_sel,
  output logic [4:0] q_number,
  output logic       q_valid,
  output logic       correct,
  output logic       wrong,
  output logic       timeout,
  output logic [7:0] q_index,
  output logic [7:0] score,
  output logic [7:0] streak,
  output logic [7:0] best_streak,
  output logic       done
);

  // An all-zero seed would lock the LFSR, so it is bumped to 1.
  localparam logic [7:0]  SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0]  LAST_Q     = 8'(NUM_QUESTIONS);
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESENT  = 3'd1,
    WAIT_ANS = 3'd2,
    FEEDBACK = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_adv;
  logic        expected;
  logic [15:0] timer;
  logic        grade_right;
  logic        grade_wrong;
  logic        grade_tmo;
  logic [7:0]  streak_inc;

  assign lfsr_adv   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign streak_inc = streak + 8'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and grading decode; an answer in the expiry cycle beats the timeout.
  always_comb begin
    state_nxt   = state;
    grade_right = 1'b0;
    grade_wrong = 1'b0;
    grade_tmo   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = PRESENT;
      end
      PRESENT: begin
        state_nxt = WAIT_ANS;
      end
      WAIT_ANS: begin
        if (ans_valid) begin
          state_nxt = FEEDBACK;
          if (ans_yes == expected) grade_right = 1'b1;
          else                     grade_wrong = 1'b1;
        end else if (timer == TIMER_LAST) begin
          state_nxt   = FEEDBACK;
          grade_wrong = 1'b1;
          grade_tmo   = 1'b1;
        end
      end
      FEEDBACK: begin
        state_nxt = (q_index == LAST_Q) ? DONE : PRESENT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Question generation, verdict capture and answer timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= SEED;
      q_sel    <= 3'd0;
      q_number <= 5'd0;
      expected <= 1'b0;
      timer    <= 16'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            q_sel    <= lfsr[7:5];
            q_number <= lfsr[4:0];
          end
        end
        PRESENT: begin
          // Question registers have been stable a full cycle, so the checker has settled.
          expected <= ismultiple;
          timer    <= 16'd0;
        end
        WAIT_ANS: begin
          timer <= timer + 16'd1;
        end
        FEEDBACK: begin
          lfsr <= lfsr_adv;
          if (q_index != LAST_Q) begin
            q_sel    <= lfsr_adv[7:5];
            q_number <= lfsr_adv[4:0];
          end
        end
        default: begin
          timer <= 16'd0;
        end
      endcase
    end
  end

  // Quiz statistics; updated on the grading edge so they appear with the feedback pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_index     <= 8'd0;
      score       <= 8'd0;
      streak      <= 8'd0;
      best_streak <= 8'd0;
    end else if ((state == IDLE || state == DONE) && start) begin
      q_index     <= 8'd0;
      score       <= 8'd0;
      streak      <= 8'd0;
      best_streak <= 8'd0;
    end else if (grade_right) begin
      q_index <= q_index + 8'd1;
      score   <= score + 8'd1;
      streak  <= streak_inc;
      if (streak_inc > best_streak) best_streak <= streak_inc;
    end else if (grade_wrong) begin
      q_index <= q_index + 8'd1;
      streak  <= 8'd0;
    end
  end

  // Registered status levels and one-cycle feedback pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      correct <= 1'b0;
      wrong   <= 1'b0;
      timeout <= 1'b0;
      done    <= 1'b0;
    end else begin
      q_valid <= (state_nxt == WAIT_ANS);
      done    <= (state_nxt == DONE);
      correct <= grade_right;
      wrong   <= grade_wrong;
      timeout <= grade_tmo;
    end
  end

endmodule
